// File: rtl/index_mask_decoder.sv
// Decodes per-cycle bit indices to one-hot, accumulates a pending mask,
// and offers it to a bitmap consumer over a valid/ready handshake.
module index_mask_decoder #(
   parameter  int WIDTH   = 64,
   parameter  int PORTS   = 2,
   parameter  int THRESH  = 8,
   parameter  int TIMEOUT = 16,
   localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int CW      = $clog2(WIDTH + 1),
   localparam int AW      = $clog2(TIMEOUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PORTS-1:0]      in_valid,
   input  logic [PORTS*IW-1:0]   in_idx,
   output logic                  in_ready,
   input  logic                  flush,
   output logic [WIDTH-1:0]      mask_out,
   output logic [CW-1:0]         mask_count,
   output logic                  mask_valid,
   input  logic                  mask_ready,
   output logic                  dup_err,
   output logic                  range_err
);

   typedef enum logic {
      ACCUM = 1'b0,
      OFFER = 1'b1
   } state_t;

   localparam bit POW2 = (WIDTH == (1 << IW));

   state_t           state, state_d;
   logic [WIDTH-1:0] pending, pending_d;
   logic [CW-1:0]    count, count_d;
   logic [AW-1:0]    age, age_d;
   logic             dup_d, range_d;

   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] pending_nx;
   logic [CW-1:0]    count_nx;
   logic [IW-1:0]    idx;
   logic             acc;
   logic             dup_new;
   logic             rng_new;
   logic             timeout_hit;
   logic             fire;

   function automatic logic [CW-1:0] popcnt(
      input logic [WIDTH-1:0] v
   );
      logic [CW-1:0] s;
      s = '0;
      for (int i = 0; i < WIDTH; i++)
         s = s + CW'(v[i]);
      return s;
   endfunction

   function automatic logic in_range(
      input logic [IW-1:0] i
   );
      return POW2 || (32'(i) < 32'(WIDTH));
   endfunction

   // Decode accepted ports; hit doubles as the same-cycle duplicate detector.
   always_comb begin
      hit     = '0;
      idx     = '0;
      acc     = 1'b0;
      dup_new = 1'b0;
      rng_new = 1'b0;
      if (state == ACCUM) begin
         for (int p = 0; p < PORTS; p++) begin
            idx = in_idx[p*IW +: IW];
            if (in_valid[p]) begin
               acc = 1'b1;
               if (!in_range(idx)) begin
                  rng_new = 1'b1;
               end else begin
                  if (pending[idx] || hit[idx])
                     dup_new = 1'b1;
                  hit[idx] = 1'b1;
               end
            end
         end
      end
   end

   assign pending_nx  = pending | hit;
   assign count_nx    = popcnt(pending_nx);
   assign timeout_hit = !acc && (pending != '0) &&
                        (age == AW'(TIMEOUT - 1));
   assign fire        = (pending_nx != '0) &&
                        ((count_nx >= CW'(THRESH)) ||
                         timeout_hit || flush);

   always_comb begin
      state_d   = state;
      pending_d = pending;
      count_d   = count;
      age_d     = age;
      dup_d     = dup_err | dup_new;
      range_d   = range_err | rng_new;
      unique case (state)
         ACCUM: begin
            pending_d = pending_nx;
            count_d   = count_nx;
            if (acc)
               age_d = '0;
            else if (pending != '0)
               age_d = age + AW'(1);
            if (fire)
               state_d = OFFER;
         end
         OFFER: begin
            if (mask_ready) begin
               pending_d = '0;
               count_d   = '0;
               age_d     = '0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         pending   <= '0;
         count     <= '0;
         age       <= '0;
         dup_err   <= 1'b0;
         range_err <= 1'b0;
      end else begin
         state     <= state_d;
         pending   <= pending_d;
         count     <= count_d;
         age       <= age_d;
         dup_err   <= dup_d;
         range_err <= range_d;
      end
   end

   assign in_ready   = (state == ACCUM);
   assign mask_valid = (state == OFFER);
   assign mask_out   = mask_valid ? pending : '0;
   assign mask_count = mask_valid ? count : '0;

endmodule

// File: tb/tb_index_mask_decoder.sv
// Directed bench for index_mask_decoder: 64-bit instance for the main
// scenarios, 48-bit instance for out-of-range indices and reset mid-offer.
module tb_index_mask_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  a_valid;
   logic [11:0] a_idx;
   logic        a_ready;
   logic        a_flush;
   logic [63:0] a_mask;
   logic [6:0]  a_cnt;
   logic        a_mvalid;
   logic        a_mready;
   logic        a_dup;
   logic        a_rng;

   logic [1:0]  b_valid;
   logic [11:0] b_idx;
   logic        b_ready;
   logic        b_flush;
   logic [47:0] b_mask;
   logic [5:0]  b_cnt;
   logic        b_mvalid;
   logic        b_mready;
   logic        b_dup;
   logic        b_rng;

   int checks = 0;
   int failures = 0;

   index_mask_decoder #(.WIDTH(64), .PORTS(2), .THRESH(8), .TIMEOUT(16)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_valid), .in_idx(a_idx), .in_ready(a_ready),
      .flush(a_flush),
      .mask_out(a_mask), .mask_count(a_cnt),
      .mask_valid(a_mvalid), .mask_ready(a_mready),
      .dup_err(a_dup), .range_err(a_rng)
   );

   index_mask_decoder #(.WIDTH(48), .PORTS(2), .THRESH(8), .TIMEOUT(16)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_valid), .in_idx(b_idx), .in_ready(b_ready),
      .flush(b_flush),
      .mask_out(b_mask), .mask_count(b_cnt),
      .mask_valid(b_mvalid), .mask_ready(b_mready),
      .dup_err(b_dup), .range_err(b_rng)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pop64(input logic [63:0] v);
      int s = 0;
      for (int i = 0; i < 64; i++) s += int'(v[i]);
      return s;
   endfunction

   task automatic release_a();
      a_valid  = 2'b00;
      a_flush  = 1'b0;
      a_mready = 1'b1;
      tick();
      a_mready = 1'b0;
      checks++;
      if (a_mvalid !== 1'b0 || a_ready !== 1'b1) begin
         failures++;
         $display("FAIL release: mvalid=%b ready=%b want 0/1", a_mvalid, a_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = '0; a_idx = '0; a_flush = 0; a_mready = 0;
      b_valid = '0; b_idx = '0; b_flush = 0; b_mready = 0;
      #12;
      checks++;
      if (a_ready !== 1'b1 || a_mvalid !== 1'b0 || a_mask !== 64'd0 ||
          a_cnt !== 7'd0 || a_dup !== 1'b0 || a_rng !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: ready=%b mvalid=%b mask=%h cnt=%0d dup=%b rng=%b want 1/0/0/0/0/0",
                  a_ready, a_mvalid, a_mask, a_cnt, a_dup, a_rng);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      a_flush = 1'b1;
      tick();
      checks++;
      if (a_mvalid !== 1'b0) begin
         failures++;
         $display("FAIL empty_flush: mvalid=%b want 0", a_mvalid);
      end
      a_flush = 1'b0;
      a_valid = 2'b11;
      a_idx = {6'd5, 6'd3};
      tick();
      a_valid = 2'b00;
      checks++;
      if (a_mvalid !== 1'b0) begin
         failures++;
         $display("FAIL pre_flush: mvalid=%b want 0", a_mvalid);
      end
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      checks++;
      if (a_mvalid !== 1'b1 || a_mask !== 64'h28 || a_cnt !== 7'd2) begin
         failures++;
         $display("FAIL flush_offer: mvalid=%b mask=%h cnt=%0d want 1/28/2",
                  a_mvalid, a_mask, a_cnt);
      end
      a_flush = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (a_mvalid !== 1'b1 || a_mask !== 64'h28 ||
             a_cnt !== 7'd2 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_%0d: mvalid=%b mask=%h cnt=%0d ready=%b want 1/28/2/0",
                     k, a_mvalid, a_mask, a_cnt, a_ready);
         end
      end
      release_a();
   endtask

   task automatic test_threshold();
      logic [11:0] pairs [4];
      pairs[0] = {6'd11, 6'd10};
      pairs[1] = {6'd13, 6'd12};
      pairs[2] = {6'd15, 6'd14};
      pairs[3] = {6'd17, 6'd16};
      for (int k = 0; k < 4; k++) begin
         a_valid = 2'b11;
         a_idx = pairs[k];
         tick();
         checks++;
         if (a_mvalid !== (k == 3)) begin
            failures++;
            $display("FAIL thresh_cycle_%0d: mvalid=%b want %b", k, a_mvalid, (k == 3));
         end
      end
      a_valid = 2'b00;
      checks++;
      if (a_mask !== 64'h3FC00 || a_cnt !== 7'd8) begin
         failures++;
         $display("FAIL thresh_offer: mask=%h cnt=%0d want 3fc00/8", a_mask, a_cnt);
      end
      release_a();
   endtask

   task automatic test_timeout();
      a_valid = 2'b01;
      a_idx = {6'd0, 6'd63};
      tick();
      a_valid = 2'b00;
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++;
         if (a_mvalid !== (k == 16)) begin
            failures++;
            $display("FAIL timeout_cycle_%0d: mvalid=%b want %b", k, a_mvalid, (k == 16));
         end
      end
      checks++;
      if (a_mask !== 64'h8000_0000_0000_0000 || a_cnt !== 7'd1) begin
         failures++;
         $display("FAIL timeout_mask: mask=%h cnt=%0d want 8000000000000000/1", a_mask, a_cnt);
      end
      release_a();
   endtask

   task automatic test_dup();
      a_valid = 2'b11;
      a_idx = {6'd9, 6'd9};
      tick();
      checks++;
      if (a_dup !== 1'b1) begin
         failures++;
         $display("FAIL dup_same_cycle: dup=%b want 1", a_dup);
      end
      a_valid = 2'b01;
      tick();
      a_valid = 2'b00;
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      checks++;
      if (a_dup !== 1'b1 || a_mvalid !== 1'b1 ||
          a_mask !== 64'h200 || a_cnt !== 7'd1 || a_rng !== 1'b0) begin
         failures++;
         $display("FAIL dup_offer: dup=%b mvalid=%b mask=%h cnt=%0d rng=%b want 1/1/200/1/0",
                  a_dup, a_mvalid, a_mask, a_cnt, a_rng);
      end
      release_a();
   endtask

   task automatic test_range_reset();
      b_valid = 2'b11;
      b_idx = {6'd2, 6'd50};
      tick();
      b_valid = 2'b00;
      checks++;
      if (b_rng !== 1'b1 || b_dup !== 1'b0) begin
         failures++;
         $display("FAIL range_flag: rng=%b dup=%b want 1/0", b_rng, b_dup);
      end
      b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      checks++;
      if (b_mvalid !== 1'b1 || b_mask !== 48'h4 || b_cnt !== 6'd1) begin
         failures++;
         $display("FAIL range_offer: mvalid=%b mask=%h cnt=%0d want 1/4/1",
                  b_mvalid, b_mask, b_cnt);
      end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (b_mvalid !== 1'b0 || b_mask !== 48'd0 || b_cnt !== 6'd0 ||
          b_ready !== 1'b1 || b_rng !== 1'b0 || b_dup !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_offer: mvalid=%b mask=%h cnt=%0d ready=%b rng=%b dup=%b want 0/0/0/1/0/0",
                  b_mvalid, b_mask, b_cnt, b_ready, b_rng, b_dup);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++;
      if (b_mvalid !== 1'b0 || a_dup !== 1'b0) begin
         failures++;
         $display("FAIL after_reset: b_mvalid=%b a_dup=%b want 0/0", b_mvalid, a_dup);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  ord [64];
      logic [63:0] model = '0;
      logic [63:0] seen = '0;
      logic [63:0] tmp;
      int ptr = 0;
      int offers = 0;
      int cyc = 0;
      logic acc;
      for (int i = 0; i < 64; i++) ord[i] = 6'((i * 37) % 64);
      a_mready = 1'b1;
      while (cyc < 200 && (ptr < 32 || model != '0)) begin
         if (ptr < 32) begin
            a_valid = 2'b11;
            a_idx = {ord[2*ptr+1], ord[2*ptr]};
         end else begin
            a_valid = 2'b00;
         end
         acc = a_ready && (ptr < 32);
         tick();
         cyc++;
         if (acc) begin
            tmp = '0;
            tmp[ord[2*ptr]] = 1'b1;
            tmp[ord[2*ptr+1]] = 1'b1;
            model = model | tmp;
            ptr++;
         end
         checks++;
         if (a_mvalid !== (pop64(model) >= 8) || a_ready !== (pop64(model) < 8)) begin
            failures++;
            $display("FAIL b2b_handshake_%0d: mvalid=%b ready=%b model_cnt=%0d",
                     cyc, a_mvalid, a_ready, pop64(model));
         end
         if (a_mvalid === 1'b1) begin
            checks++;
            if (a_mask !== model || a_cnt !== 7'(pop64(model)) ||
                (seen & a_mask) != '0) begin
               failures++;
               $display("FAIL b2b_offer_%0d: mask=%h cnt=%0d want %h/%0d",
                        offers, a_mask, a_cnt, model, pop64(model));
            end
            seen = seen | a_mask;
            offers++;
            model = '0;
         end
      end
      a_valid = 2'b00;
      a_mready = 1'b0;
      checks++;
      if (seen !== {64{1'b1}} || offers != 8 || ptr != 32) begin
         failures++;
         $display("FAIL b2b_total: seen=%h offers=%0d ptr=%0d want all-ones/8/32",
                  seen, offers, ptr);
      end
   endtask

   initial begin
      test_reset();
      test_flush();
      test_threshold();
      test_timeout();
      test_dup();
      test_range_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
